// File: rtl/lanzador_captura_rizado.sv
// Operand-launch / result-capture stage around an external WIDTH-bit
// ripple-carry adder. Operands are registered and held static between
// launches, the stage waits SETTLE cycles for the carry to ripple, then
// captures sum and carry and offers them on a valid/ready handshake.
//
// Build option: define RIZADO_ACUM_EN for accumulate mode, where the adder's
// A operand is fed back from the last captured sum instead of in_a.
module lanzador_captura_rizado #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  output logic             busy
);

  // The settle counter must be able to hold SETTLE-1, and zero cycles of
  // settling would sample the adder in the same cycle its operands change.
  if (SETTLE < 1 || SETTLE > (2**CNT_W) - 1) begin : g_bad_settle
    $error("lanzador_captura_rizado: SETTLE=%0d outside 1..%0d", SETTLE, (2**CNT_W) - 1);
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               ci_q, ci_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               co_q, co_d;
  logic               vld_q, vld_d;

  logic               accept;
  logic               capture;
  logic               hand_off;

  assign accept   = (state_q == S_IDLE) && in_valid;
  assign capture  = (state_q == S_SETTLE) && (cnt_q == '0);
  assign hand_off = (state_q == S_HOLD) && out_ready;

  // State and settle counter; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: IDLE -> SETTLE on accept, SETTLE -> HOLD when the count expires,
  // HOLD -> IDLE when the consumer takes the result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_W'(SETTLE - 1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode straight from state.
  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
  end

  // Operand and result registers: operands move only on accept so the adder
  // sees no toggling between real operations; results move only on capture.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    ci_d  = ci_q;
    s_d   = s_q;
    co_d  = co_q;
    vld_d = vld_q;
    if (accept) begin
`ifdef RIZADO_ACUM_EN
      a_d = s_q;
`else
      a_d = in_a;
`endif
      b_d  = in_b;
      ci_d = in_ci;
    end
    if (capture) begin
      s_d   = add_s;
      co_d  = add_co;
      vld_d = 1'b1;
    end
    if (hand_off) begin
      vld_d = 1'b0;
    end
  end

`ifdef RIZADO_ACUM_EN
  // in_a has no consumer in accumulate mode; the port stays for a uniform pinout.
  logic unused_in_a;
  assign unused_in_a = ^in_a;
`endif

  // Register bank for operands and captured result, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      ci_q  <= 1'b0;
      s_q   <= '0;
      co_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      ci_q  <= ci_d;
      s_q   <= s_d;
      co_q  <= co_d;
      vld_q <= vld_d;
    end
  end

  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_ci    = ci_q;
  assign out_s     = s_q;
  assign out_co    = co_q;
  assign out_valid = vld_q;

endmodule
